// File: rtl/plru_pkg.sv
// Shared types and sizing helpers for the tree-PLRU replacement controller.
package plru_pkg;

    localparam int TREE_LVL_COUNT_DEFAULT = 3;
    localparam int WAY_COUNT_DEFAULT      = 1 << TREE_LVL_COUNT_DEFAULT;
    localparam int NODE_COUNT_DEFAULT     = WAY_COUNT_DEFAULT - 1;

    typedef logic [NODE_COUNT_DEFAULT-1:0] plru_node_t;

    typedef enum logic {
        PLRU_IDLE,
        PLRU_FLUSH
    } plru_fsm_e;

    function automatic int way_count(input int lvl);
        return 1 << lvl;
    endfunction

    function automatic int node_count(input int lvl);
        return (1 << lvl) - 1;
    endfunction

    // Nodes are stored pre-order: root, whole left subtree, whole right subtree.
    function automatic int node_lo(input int lvl, input int n);
        int idx;
        int lo;
        int ways;
        idx  = n;
        lo   = 0;
        ways = 1 << lvl;
        while (idx != 0) begin
            ways = ways / 2;
            idx  = idx - 1;
            if (idx >= ways - 1) begin
                idx = idx - (ways - 1);
                lo  = lo + ways;
            end
        end
        return lo;
    endfunction

    function automatic int node_span(input int lvl, input int n);
        int idx;
        int ways;
        idx  = n;
        ways = 1 << lvl;
        while (idx != 0) begin
            ways = ways / 2;
            idx  = idx - 1;
            if (idx >= ways - 1) begin
                idx = idx - (ways - 1);
            end
        end
        return ways;
    endfunction

endpackage

// File: rtl/plru_tree_logic.sv
// Combinational tree-PLRU kernel: next node vector for an access mask, and the
// one-hot victim the current node vector points at.
module plru_tree_logic
    import plru_pkg::*;
#(
    parameter  int TREE_LVL_COUNT = 3,
    localparam int WAY_COUNT      = way_count(TREE_LVL_COUNT),
    localparam int NODE_COUNT     = node_count(TREE_LVL_COUNT)
) (
    input  logic [NODE_COUNT-1:0] node_old,
    input  logic [WAY_COUNT-1:0]  access_mask,
    output logic [NODE_COUNT-1:0] node_new,
    output logic [WAY_COUNT-1:0]  victim_mask
);

    for (genvar n = 0; n < NODE_COUNT; n++) begin : g_node
        localparam int LO   = node_lo(TREE_LVL_COUNT, n);
        localparam int HALF = node_span(TREE_LVL_COUNT, n) / 2;
        logic left_hit;
        logic right_hit;
        assign left_hit    = |access_mask[LO +: HALF];
        assign right_hit   = |access_mask[LO+HALF +: HALF];
        // A node flips only when the side it points to was accessed.
        assign node_new[n] = node_old[n] ^ (node_old[n] ? right_hit : left_hit);
    end

    always_comb begin
        victim_mask = '0;
        for (int w = 0; w < WAY_COUNT; w++) begin
            int   node;
            int   lo;
            int   ways;
            logic hit;
            node = 0;
            lo   = 0;
            ways = WAY_COUNT;
            hit  = 1'b1;
            for (int d = 0; d < TREE_LVL_COUNT; d++) begin
                ways = ways / 2;
                if (w >= lo + ways) begin
                    hit  = hit & node_old[node];
                    node = node + ways;
                    lo   = lo + ways;
                end else begin
                    hit  = hit & ~node_old[node];
                    node = node + 1;
                end
            end
            victim_mask[w] = hit;
        end
    end

endmodule

// File: rtl/plru_replacer.sv
// Per-set tree-PLRU state with hit touches, registered victim responses and a
// sequenced flush. Define PLRU_ALLOC_TOUCH_EN to promote each victim to MRU.
module plru_replacer
    import plru_pkg::*;
#(
    parameter  int TREE_LVL_COUNT = 3,
    parameter  int SET_COUNT      = 16,
    localparam int WAY_COUNT      = way_count(TREE_LVL_COUNT),
    localparam int NODE_COUNT     = node_count(TREE_LVL_COUNT),
    localparam int SET_W          = $clog2(SET_COUNT)
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 touch_vld_i,
    input  logic [SET_W-1:0]     touch_set_i,
    input  logic [WAY_COUNT-1:0] touch_way_mask_i,
    input  logic                 victim_req_vld_i,
    output logic                 victim_req_rdy_o,
    input  logic [SET_W-1:0]     victim_set_i,
    output logic                 victim_rsp_vld_o,
    output logic [WAY_COUNT-1:0] victim_way_mask_o,
    input  logic                 flush_i,
    output logic                 busy_o
);

    plru_fsm_e               state;
    plru_fsm_e               state_nxt;
    logic [SET_W-1:0]        flush_cnt;
    logic [SET_W-1:0]        flush_cnt_nxt;
    logic [NODE_COUNT-1:0]   nodes [SET_COUNT];

    logic                    touch_en;
    logic                    req_acc;
    logic                    alloc_en;
    logic [NODE_COUNT-1:0]   touch_old;
    logic [NODE_COUNT-1:0]   touch_new;
    logic [WAY_COUNT-1:0]    touch_vic_unused;
    logic [NODE_COUNT-1:0]   victim_old;
    logic [NODE_COUNT-1:0]   victim_node_unused;
    logic [WAY_COUNT-1:0]    victim_mask;
    logic [NODE_COUNT-1:0]   alloc_new;

    assign touch_en  = touch_vld_i && (state == PLRU_IDLE);
    assign req_acc   = victim_req_vld_i && (state == PLRU_IDLE);
    assign touch_old = nodes[touch_set_i];

    plru_tree_logic #(.TREE_LVL_COUNT(TREE_LVL_COUNT)) u_touch (
        .node_old    (touch_old),
        .access_mask (touch_way_mask_i),
        .node_new    (touch_new),
        .victim_mask (touch_vic_unused)
    );

    // Same-set touch is forwarded so the victim reflects this cycle's hit.
    assign victim_old = (touch_en && (touch_set_i == victim_set_i)) ? touch_new
                                                                    : nodes[victim_set_i];

    plru_tree_logic #(.TREE_LVL_COUNT(TREE_LVL_COUNT)) u_victim (
        .node_old    (victim_old),
        .access_mask ('0),
        .node_new    (victim_node_unused),
        .victim_mask (victim_mask)
    );

`ifdef PLRU_ALLOC_TOUCH_EN
    logic [WAY_COUNT-1:0] alloc_vic_unused;

    plru_tree_logic #(.TREE_LVL_COUNT(TREE_LVL_COUNT)) u_alloc (
        .node_old    (victim_old),
        .access_mask (victim_mask),
        .node_new    (alloc_new),
        .victim_mask (alloc_vic_unused)
    );
    assign alloc_en = req_acc;
`else
    assign alloc_new = victim_old;
    assign alloc_en  = 1'b0;
`endif

    // Control: flush sequencer
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= PLRU_IDLE;
            flush_cnt <= '0;
        end else begin
            state     <= state_nxt;
            flush_cnt <= flush_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        flush_cnt_nxt = flush_cnt;
        unique case (state)
            PLRU_IDLE: begin
                if (flush_i) begin
                    state_nxt     = PLRU_FLUSH;
                    flush_cnt_nxt = '0;
                end
            end
            PLRU_FLUSH: begin
                if (flush_cnt == SET_W'(SET_COUNT - 1)) begin
                    state_nxt = PLRU_IDLE;
                end else begin
                    flush_cnt_nxt = flush_cnt + 1'b1;
                end
            end
            default: state_nxt = PLRU_IDLE;
        endcase
    end

    assign victim_req_rdy_o = (state == PLRU_IDLE);
    assign busy_o           = (state == PLRU_FLUSH);

    // Node state: flush clear wins, then allocation promote, then hit touch
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int s = 0; s < SET_COUNT; s++) begin
                nodes[s] <= '0;
            end
        end else begin
            for (int s = 0; s < SET_COUNT; s++) begin
                if ((state == PLRU_FLUSH) && (flush_cnt == SET_W'(s))) begin
                    nodes[s] <= '0;
                end else if (alloc_en && (victim_set_i == SET_W'(s))) begin
                    nodes[s] <= alloc_new;
                end else if (touch_en && (touch_set_i == SET_W'(s))) begin
                    nodes[s] <= touch_new;
                end
            end
        end
    end

    // Response stage: mask holds between pulses
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            victim_rsp_vld_o  <= 1'b0;
            victim_way_mask_o <= '0;
        end else begin
            victim_rsp_vld_o <= req_acc;
            if (req_acc) begin
                victim_way_mask_o <= victim_mask;
            end
        end
    end

endmodule

// File: tb/tb_plru_replacer.sv
// Randomized bench for plru_replacer with a recursive behavioural PLRU model.
module tb_plru_replacer;

    localparam int LVL   = 3;
    localparam int SETS  = 4;
    localparam int WAYS  = 8;
    localparam int NODES = 7;
    localparam int SW    = 2;

    logic            clk = 1'b0;
    logic            rstn = 1'b0;
    logic            touch_vld = 1'b0;
    logic [SW-1:0]   touch_set = '0;
    logic [WAYS-1:0] touch_mask = '0;
    logic            req_vld = 1'b0;
    logic            req_rdy;
    logic [SW-1:0]   req_set = '0;
    logic            rsp_vld;
    logic [WAYS-1:0] rsp_mask;
    logic            flush = 1'b0;
    logic            busy;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    plru_replacer #(.TREE_LVL_COUNT(LVL), .SET_COUNT(SETS)) dut (
        .clk               (clk),
        .rstn              (rstn),
        .touch_vld_i       (touch_vld),
        .touch_set_i       (touch_set),
        .touch_way_mask_i  (touch_mask),
        .victim_req_vld_i  (req_vld),
        .victim_req_rdy_o  (req_rdy),
        .victim_set_i      (req_set),
        .victim_rsp_vld_o  (rsp_vld),
        .victim_way_mask_o (rsp_mask),
        .flush_i           (flush),
        .busy_o            (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [NODES-1:0] m_tree [SETS];
    bit               m_flush;
    int               m_cnt;
    logic             m_vld;
    logic [WAYS-1:0]  m_mask;

    // Walk the pointers; the right child of a subtree root sits after its left subtree.
    function automatic int m_victim(input logic [NODES-1:0] t);
        int node = 0;
        int lo   = 0;
        int n    = WAYS;
        while (n > 1) begin
            int half = n / 2;
            if (t[node]) begin
                node = node + half;
                lo   = lo + half;
            end else begin
                node = node + 1;
            end
            n = half;
        end
        return lo;
    endfunction

    function automatic logic [NODES-1:0] m_touch_rec(input logic [NODES-1:0] t_old,
                                                     input logic [NODES-1:0] t_acc,
                                                     input int node, input int lo, input int n,
                                                     input logic [WAYS-1:0] mask);
        logic [NODES-1:0] r;
        int  half;
        bit  left_any;
        bit  right_any;
        r = t_acc;
        if (n < 2) return r;
        half      = n / 2;
        left_any  = 0;
        right_any = 0;
        for (int w = 0; w < half; w++) begin
            if (mask[lo + w])        left_any  = 1;
            if (mask[lo + half + w]) right_any = 1;
        end
        if (t_old[node] ? right_any : left_any) r[node] = ~t_old[node];
        r = m_touch_rec(t_old, r, node + 1, lo, half, mask);
        r = m_touch_rec(t_old, r, node + half, lo + half, half, mask);
        return r;
    endfunction

    function automatic logic [NODES-1:0] m_touch(input logic [NODES-1:0] t, input logic [WAYS-1:0] mask);
        return m_touch_rec(t, t, 0, 0, WAYS, mask);
    endfunction

    initial begin
        forever begin
            @(posedge clk or negedge rstn);
            if (!rstn) begin
                for (int s = 0; s < SETS; s++) m_tree[s] = '0;
                m_flush = 0;
                m_cnt   = 0;
                m_vld   = 0;
                m_mask  = '0;
            end else if (m_flush) begin
                m_tree[m_cnt] = '0;
                m_vld = 0;
                if (m_cnt == SETS - 1) m_flush = 0;
                else m_cnt++;
            end else begin
                if (touch_vld) m_tree[touch_set] = m_touch(m_tree[touch_set], touch_mask);
                m_vld = req_vld;
                if (req_vld) begin
                    m_mask = WAYS'(1) << m_victim(m_tree[req_set]);
`ifdef PLRU_ALLOC_TOUCH_EN
                    m_tree[req_set] = m_touch(m_tree[req_set], m_mask);
`endif
                end
                if (flush) begin
                    m_flush = 1;
                    m_cnt   = 0;
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(negedge clk);
            check("busy",     32'(busy),     32'(m_flush));
            check("rdy",      32'(req_rdy),  32'(!m_flush));
            check("rsp_vld",  32'(rsp_vld),  32'(m_vld));
            check("rsp_mask", 32'(rsp_mask), 32'(m_mask));
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // ---------------- directed helpers ----------------
    task automatic do_touch(input int s, input logic [WAYS-1:0] mask);
        @(negedge clk);
        touch_vld  = 1'b1;
        touch_set  = SW'(s);
        touch_mask = mask;
        @(negedge clk);
        touch_vld  = 1'b0;
    endtask

    task automatic req_expect(input int s, input logic [WAYS-1:0] exp, input string name);
        @(negedge clk);
        req_vld = 1'b1;
        req_set = SW'(s);
        @(negedge clk);
        req_vld = 1'b0;
        check(name, 32'(rsp_mask), 32'(exp));
        check({name, "_vld"}, 32'(rsp_vld), 32'd1);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("reset_vld",  32'(rsp_vld),  32'd0);
        check("reset_mask", 32'(rsp_mask), 32'd0);
        check("reset_busy", 32'(busy),     32'd0);
        check("reset_rdy",  32'(req_rdy),  32'd1);
        rstn = 1'b1;

        req_expect(0, 8'h01, "first_victim");

        do_touch(0, 8'h01);
        req_expect(0, 8'h10, "touch0_victim");
        req_expect(1, 8'h01, "set1_untouched");

        for (int w = 0; w < WAYS; w++) do_touch(2, WAYS'(1) << w);
        req_expect(2, 8'h01, "sweep_victim");

        @(negedge clk);
        touch_vld  = 1'b1;
        touch_set  = 2'd3;
        touch_mask = 8'h01;
        req_vld    = 1'b1;
        req_set    = 2'd3;
        @(negedge clk);
        touch_vld  = 1'b0;
        req_vld    = 1'b0;
        check("bypass_victim", 32'(rsp_mask), 32'h10);
`ifdef PLRU_ALLOC_TOUCH_EN
        req_expect(3, 8'h04, "alloc_second");
`else
        req_expect(3, 8'h10, "noalloc_second");
`endif

        // Flush sequence with a dropped mid-flush touch.
        for (int s = 0; s < SETS; s++) do_touch(s, 8'h01 << s);
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        for (int c = 0; c < SETS; c++) begin
            check("flush_busy", 32'(busy),    32'd1);
            check("flush_rdy",  32'(req_rdy), 32'd0);
            if (c == 1) begin
                touch_vld  = 1'b1;
                touch_set  = 2'd0;
                touch_mask = 8'h01;
            end else begin
                touch_vld  = 1'b0;
            end
            @(negedge clk);
        end
        touch_vld = 1'b0;
        check("flush_done_busy", 32'(busy),    32'd0);
        check("flush_done_rdy",  32'(req_rdy), 32'd1);
        for (int s = 0; s < SETS; s++) req_expect(s, 8'h01, "post_flush");

        // Reset during flush.
        for (int s = 0; s < SETS; s++) do_touch(s, 8'h80 >> s);
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        @(negedge clk);
        #2 rstn = 1'b0;
        #1;
        check("rst_mid_busy", 32'(busy),    32'd0);
        check("rst_mid_rdy",  32'(req_rdy), 32'd1);
        @(negedge clk);
        rstn = 1'b1;
        for (int s = 0; s < SETS; s++) req_expect(s, 8'h01, "post_reset");

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            touch_vld = 1'($urandom_range(0, 1));
            touch_set = SW'($urandom_range(0, SETS - 1));
            case ($urandom_range(0, 7))
                0:       touch_mask = 8'h00;
                1:       touch_mask = 8'($urandom);
                default: touch_mask = 8'h01 << $urandom_range(0, WAYS - 1);
            endcase
            req_vld = 1'($urandom_range(0, 1));
            req_set = SW'($urandom_range(0, SETS - 1));
            if ($urandom_range(0, 7) == 0) req_set = touch_set;
            flush   = ($urandom_range(0, 99) == 0);
        end
        @(negedge clk);
        touch_vld = 1'b0;
        req_vld   = 1'b0;
        flush     = 1'b0;
        repeat (SETS + 2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
